// File: rtl/decode_queue.sv
// decode_queue
//   Decodes one RV32I instruction per cycle into a micro-op and buffers it in a
//   DEPTH-entry FIFO that the dispatcher drains with a valid/ready handshake.
//   Also produces the next-fetch PC combinationally from the incoming word.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   rdy               global enable; 0 freezes pointers/count and blocks I/O
//   flush             synchronous FIFO clear (mispredict recovery)
//   in_valid/in_ready fetch handshake; in_inst/in_pc/in_predict payload
//   pred_target       next-fetch PC for the presented instruction (comb)
//   out_valid/out_ready dispatch handshake for the head entry
//   out_*             head entry fields (shown at all times)
//   count             number of occupied entries
//
// newop encoding (OPW = 5):
//   0 NOP  1 ADD  2 SUB  3 SLL  4 SLT  5 SLTU 6 XOR  7 SRL  8 SRA  9 OR  10 AND
//   11 LB 12 LH 13 LW 14 LBU 15 LHU 16 SB 17 SH 18 SW
//   19 BEQ 20 BNE 21 BLT 22 BGE 23 BLTU 24 BGEU 25 LUI 26 AUIPC 27 JAL 28 JALR
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int OPW   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [XLEN-1:0]            in_pc,
  input  logic                       in_predict,
  output logic [XLEN-1:0]            pred_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPW-1:0]             out_newop,
  output logic [XLEN-1:0]            out_pc,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_wr_rd,
  output logic                       out_is_branch,
  output logic                       out_is_mem,
  output logic                       out_predict,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_RI     = 7'b0010011;
  localparam logic [6:0] OPC_RR     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [OPW-1:0] OP_NOP   = OPW'(5'd0);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(5'd1);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(5'd2);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(5'd3);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(5'd4);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(5'd5);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(5'd6);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(5'd7);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(5'd8);
  localparam logic [OPW-1:0] OP_OR    = OPW'(5'd9);
  localparam logic [OPW-1:0] OP_AND   = OPW'(5'd10);
  localparam logic [OPW-1:0] OP_LB    = OPW'(5'd11);
  localparam logic [OPW-1:0] OP_LH    = OPW'(5'd12);
  localparam logic [OPW-1:0] OP_LW    = OPW'(5'd13);
  localparam logic [OPW-1:0] OP_LBU   = OPW'(5'd14);
  localparam logic [OPW-1:0] OP_LHU   = OPW'(5'd15);
  localparam logic [OPW-1:0] OP_SB    = OPW'(5'd16);
  localparam logic [OPW-1:0] OP_SH    = OPW'(5'd17);
  localparam logic [OPW-1:0] OP_SW    = OPW'(5'd18);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(5'd19);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(5'd20);
  localparam logic [OPW-1:0] OP_BLT   = OPW'(5'd21);
  localparam logic [OPW-1:0] OP_BGE   = OPW'(5'd22);
  localparam logic [OPW-1:0] OP_BLTU  = OPW'(5'd23);
  localparam logic [OPW-1:0] OP_BGEU  = OPW'(5'd24);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(5'd25);
  localparam logic [OPW-1:0] OP_AUIPC = OPW'(5'd26);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(5'd27);
  localparam logic [OPW-1:0] OP_JALR  = OPW'(5'd28);

  localparam logic [2:0] FMT_Z = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            wr_rd;
    logic            is_branch;
    logic            is_mem;
    logic            predict;
    logic            illegal;
  } entry_t;

  // Integer op shared by RR and RI; bit 30 selects SUB only for register form,
  // since in ADDI that bit is part of the immediate.
  function automatic logic [OPW-1:0] alu_op(input logic [2:0] f3, input logic b30,
                                            input logic is_imm);
    logic [OPW-1:0] op;
    case (f3)
      3'b000:  op = (b30 && !is_imm) ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = b30 ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      3'b111:  op = OP_AND;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd_f;
  logic [4:0]      w_rs1_f;
  logic [4:0]      w_rs2_f;
  logic [31:0]     w_imm_i;
  logic [31:0]     w_imm_s;
  logic [31:0]     w_imm_b;
  logic [31:0]     w_imm_u;
  logic [31:0]     w_imm_j;
  logic [OPW-1:0]  w_op;
  logic            w_legal;
  logic [2:0]      w_fmt;
  logic            w_writes;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_branch;
  logic            w_mem;
  logic [XLEN-1:0] w_imm;
  entry_t          w_ent;
  entry_t          w_head;
  logic            w_push;
  logic            w_pop;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  assign w_opc   = in_inst[6:0];
  assign w_f3    = in_inst[14:12];
  assign w_rd_f  = in_inst[11:7];
  assign w_rs1_f = in_inst[19:15];
  assign w_rs2_f = in_inst[24:20];

  assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
  assign w_imm_u = {in_inst[31:12], 12'h000};
  assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};

  // Opcode/funct3 classification into op, immediate format and side flags.
  always_comb begin
    w_op      = OP_NOP;
    w_legal   = 1'b1;
    w_fmt     = FMT_Z;
    w_writes  = 1'b0;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    w_branch  = 1'b0;
    w_mem     = 1'b0;
    case (w_opc)
      OPC_RI: begin
        w_fmt    = FMT_I;
        w_writes = 1'b1;
        // The canonical NOP encoding is reported as NOP rather than ADD.
        if (in_inst == 32'h0000_0013) begin
          w_op = OP_NOP;
        end else begin
          w_op = alu_op(w_f3, in_inst[30], 1'b1);
        end
      end
      OPC_RR: begin
        w_writes  = 1'b1;
        w_use_rs2 = 1'b1;
        w_op      = alu_op(w_f3, in_inst[30], 1'b0);
      end
      OPC_LOAD: begin
        w_fmt    = FMT_I;
        w_writes = 1'b1;
        w_mem    = 1'b1;
        case (w_f3)
          3'b000:  w_op = OP_LB;
          3'b001:  w_op = OP_LH;
          3'b010:  w_op = OP_LW;
          3'b100:  w_op = OP_LBU;
          3'b101:  w_op = OP_LHU;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        w_fmt     = FMT_S;
        w_use_rs2 = 1'b1;
        w_mem     = 1'b1;
        case (w_f3)
          3'b000:  w_op = OP_SB;
          3'b001:  w_op = OP_SH;
          3'b010:  w_op = OP_SW;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        w_fmt     = FMT_B;
        w_use_rs2 = 1'b1;
        w_branch  = 1'b1;
        case (w_f3)
          3'b000:  w_op = OP_BEQ;
          3'b001:  w_op = OP_BNE;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          3'b110:  w_op = OP_BLTU;
          3'b111:  w_op = OP_BGEU;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        w_fmt     = FMT_U;
        w_writes  = 1'b1;
        w_use_rs1 = 1'b0;
        w_op      = OP_LUI;
      end
      OPC_AUIPC: begin
        w_fmt    = FMT_U;
        w_writes = 1'b1;
        w_op     = OP_AUIPC;
      end
      OPC_JAL: begin
        w_fmt     = FMT_J;
        w_writes  = 1'b1;
        w_use_rs1 = 1'b0;
        w_op      = OP_JAL;
      end
      OPC_JALR: begin
        w_fmt    = FMT_I;
        w_writes = 1'b1;
        if (w_f3 == 3'b000) begin
          w_op = OP_JALR;
        end else begin
          w_legal = 1'b0;
        end
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Format-selected immediate; U is zero-extended, the rest sign-extended.
  always_comb begin
    w_imm = '0;
    if (w_legal) begin
      case (w_fmt)
        FMT_I:   w_imm = XLEN'($signed(w_imm_i));
        FMT_S:   w_imm = XLEN'($signed(w_imm_s));
        FMT_B:   w_imm = XLEN'($signed(w_imm_b));
        FMT_U:   w_imm = XLEN'(w_imm_u);
        FMT_J:   w_imm = XLEN'($signed(w_imm_j));
        default: w_imm = '0;
      endcase
    end else begin
      w_imm = '0;
    end
  end

  // Assemble the entry; an illegal word degrades to a non-writing NOP.
  always_comb begin
    w_ent           = '0;
    w_ent.op        = w_legal ? w_op : OP_NOP;
    w_ent.pc        = in_pc;
    w_ent.rs1       = w_use_rs1 ? w_rs1_f : 5'd0;
    w_ent.rs2       = (w_legal && w_use_rs2) ? w_rs2_f : 5'd0;
    w_ent.rd        = w_rd_f;
    w_ent.imm       = w_imm;
    w_ent.wr_rd     = w_legal && w_writes && (w_rd_f != 5'd0);
    w_ent.is_branch = w_legal && w_branch;
    w_ent.is_mem    = w_legal && w_mem;
    w_ent.predict   = in_predict;
    w_ent.illegal   = !w_legal;
  end

  // Next-fetch PC: taken-predicted branches and JAL redirect, else fall through.
  always_comb begin
    pred_target = in_pc + XLEN'(32'd4);
    if (w_legal && w_branch && in_predict) begin
      pred_target = in_pc + XLEN'($signed(w_imm_b));
    end else if (w_opc == OPC_JAL) begin
      pred_target = in_pc + XLEN'($signed(w_imm_j));
    end else begin
      pred_target = in_pc + XLEN'(32'd4);
    end
  end

  // Handshakes depend only on registered count and rdy (no full bypass).
  assign in_ready  = rdy && (r_count < CW'(DEPTH));
  assign out_valid = rdy && (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // Pointer and occupancy state; flush (while enabled) empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy && flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared only by reset, flush leaves contents in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_tail] <= w_ent;
    end
  end

  assign w_head        = r_mem[r_head];
  assign out_newop     = w_head.op;
  assign out_pc        = w_head.pc;
  assign out_rs1       = w_head.rs1;
  assign out_rs2       = w_head.rs2;
  assign out_rd        = w_head.rd;
  assign out_imm       = w_head.imm;
  assign out_wr_rd     = w_head.wr_rd;
  assign out_is_branch = w_head.is_branch;
  assign out_is_mem    = w_head.is_mem;
  assign out_predict   = w_head.predict;
  assign out_illegal   = w_head.illegal;
  assign count         = r_count;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int OPW   = 5;

  localparam int OP_NOP = 0,  OP_ADD = 1,  OP_SUB = 2,  OP_SLL = 3,  OP_SLT = 4;
  localparam int OP_SLTU = 5, OP_XOR = 6,  OP_SRL = 7,  OP_SRA = 8,  OP_OR = 9;
  localparam int OP_AND = 10, OP_LB = 11,  OP_LH = 12,  OP_LW = 13,  OP_LBU = 14;
  localparam int OP_LHU = 15, OP_SB = 16,  OP_SH = 17,  OP_SW = 18,  OP_BEQ = 19;
  localparam int OP_BNE = 20, OP_BLT = 21, OP_BGE = 22, OP_BLTU = 23, OP_BGEU = 24;
  localparam int OP_LUI = 25, OP_AUIPC = 26, OP_JAL = 27, OP_JALR = 28;

  localparam logic [6:0] RI = 7'h13, RR = 7'h33, LD = 7'h03, ST = 7'h23, BR = 7'h63;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;

  logic clk = 1'b0, rst = 1'b0, rdy = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, in_predict = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = 32'h0, in_pc = 32'h0;
  logic in_ready, out_valid, out_wr_rd, out_is_branch, out_is_mem, out_predict, out_illegal;
  logic [XLEN-1:0] pred_target, out_pc, out_imm;
  logic [OPW-1:0] out_newop;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [$clog2(DEPTH+1)-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    bit          wr, br, mem, pred, ill;
  } exp_t;

  exp_t mq[$];

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_predict(in_predict), .pred_target(pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_newop(out_newop), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_wr_rd(out_wr_rd), .out_is_branch(out_is_branch), .out_is_mem(out_is_mem),
    .out_predict(out_predict), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the instruction-set rules, immediates by arithmetic.
  function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc,
                                        input logic p);
    exp_t e;
    int f3;
    bit writes;
    int alu[8], ldt[8], stt[8], brt[8];
    logic [31:0] ii, si, bi, ui, ji;
    alu = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    ldt = '{OP_LB, OP_LH, OP_LW, -1, OP_LBU, OP_LHU, -1, -1};
    stt = '{OP_SB, OP_SH, OP_SW, -1, -1, -1, -1, -1};
    brt = '{OP_BEQ, OP_BNE, -1, -1, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    f3 = int'(w[14:12]);
    ii = 32'(-2048 * int'(w[31]) + int'(w[30:20]));
    si = 32'(-2048 * int'(w[31]) + 32 * int'(w[30:25]) + int'(w[11:7]));
    bi = 32'(-4096 * int'(w[31]) + 2048 * int'(w[7]) + 32 * int'(w[30:25]) + 2 * int'(w[11:8]));
    ui = w & 32'hFFFF_F000;
    ji = 32'(-1048576 * int'(w[31]) + 4096 * int'(w[19:12]) + 2048 * int'(w[20]) +
             2 * int'(w[30:21]));
    e.op = OP_NOP; e.pc = pc; e.imm = 32'h0; e.rs1 = w[19:15]; e.rs2 = 5'd0; e.rd = w[11:7];
    e.br = 1'b0; e.mem = 1'b0; e.pred = p; e.ill = 1'b0; writes = 1'b0;
    if (w[6:0] == RI) begin
      e.op = (f3 == 5 && w[30]) ? OP_SRA : alu[f3];
      if (w == 32'h0000_0013) e.op = OP_NOP;
      e.imm = ii; writes = 1'b1;
    end else if (w[6:0] == RR) begin
      e.op = alu[f3];
      if (w[30] && f3 == 0) e.op = OP_SUB;
      if (w[30] && f3 == 5) e.op = OP_SRA;
      e.rs2 = w[24:20]; writes = 1'b1;
    end else if (w[6:0] == LD) begin
      if (ldt[f3] < 0) e.ill = 1'b1;
      else begin e.op = ldt[f3]; e.imm = ii; e.mem = 1'b1; writes = 1'b1; end
    end else if (w[6:0] == ST) begin
      if (stt[f3] < 0) e.ill = 1'b1;
      else begin e.op = stt[f3]; e.imm = si; e.mem = 1'b1; e.rs2 = w[24:20]; end
    end else if (w[6:0] == BR) begin
      if (brt[f3] < 0) e.ill = 1'b1;
      else begin e.op = brt[f3]; e.imm = bi; e.br = 1'b1; e.rs2 = w[24:20]; end
    end else if (w[6:0] == LUI) begin
      e.op = OP_LUI; e.imm = ui; e.rs1 = 5'd0; writes = 1'b1;
    end else if (w[6:0] == AUIPC) begin
      e.op = OP_AUIPC; e.imm = ui; writes = 1'b1;
    end else if (w[6:0] == JAL) begin
      e.op = OP_JAL; e.imm = ji; e.rs1 = 5'd0; writes = 1'b1;
    end else if (w[6:0] == JALR && f3 == 0) begin
      e.op = OP_JALR; e.imm = ii; writes = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    e.wr = writes && (e.rd != 5'd0) && !e.ill;
    return e;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] w, input logic [31:0] pc,
                                               input logic p);
    exp_t e;
    e = model_decode(w, pc, p);
    if (e.br && p) return pc + e.imm;
    if (w[6:0] == JAL) return pc + e.imm;
    return pc + 32'd4;
  endfunction

  task automatic check_state(input string tag);
    exp_t h;
    chk({tag, ".count"}, 64'(count), 64'(mq.size()));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy && mq.size() < DEPTH));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(rdy && mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      chk({tag, ".newop"}, 64'(out_newop), 64'(h.op));
      chk({tag, ".pc"}, 64'(out_pc), 64'(h.pc));
      chk({tag, ".rs1"}, 64'(out_rs1), 64'(h.rs1));
      chk({tag, ".rs2"}, 64'(out_rs2), 64'(h.rs2));
      chk({tag, ".rd"}, 64'(out_rd), 64'(h.rd));
      chk({tag, ".imm"}, 64'(out_imm), 64'(h.imm));
      chk({tag, ".flags"},
          64'({out_wr_rd, out_is_branch, out_is_mem, out_predict, out_illegal}),
          64'({h.wr, h.br, h.mem, h.pred, h.ill}));
    end
  endtask

  // One clock: predict the model transition from current inputs, then compare.
  task automatic tick(input string tag);
    bit push, pop;
    exp_t nxt;
    chk({tag, ".pred_target"}, 64'(pred_target), 64'(model_target(in_inst, in_pc, in_predict)));
    push = in_valid && rdy && !flush && (mq.size() < DEPTH);
    pop  = out_ready && rdy && !flush && (mq.size() != 0);
    nxt  = model_decode(in_inst, in_pc, in_predict);
    @(posedge clk);
    #1;
    if (rdy && flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(nxt);
    end
    check_state(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic p, input logic ordy);
    in_valid = v; in_inst = inst; in_pc = pc; in_predict = p; out_ready = ordy;
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0] opcs[9];
    int k;
    opcs = '{RI, RR, LD, ST, BR, LUI, AUIPC, JAL, JALR};
    w = $urandom();
    k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = opcs[k];
    if (k == 8 && $urandom_range(0, 1) == 1) w[14:12] = 3'b000;
    if (k == 10) w = 32'h0000_0013;
    return w;
  endfunction

  initial begin
    // Reset state with rdy low, then rdy high.
    #1;
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.outs", 64'({out_newop, out_rd, out_wr_rd, out_illegal}), 64'd0);
    chk("rst.out_pc", 64'(out_pc), 64'd0);
    chk("rst.out_imm", 64'(out_imm), 64'd0);
    rdy = 1'b1;
    #1;
    chk("rst.in_ready_rdy", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // ADDI x1,x0,5
    drive(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
    tick("addi");
    chk("addi.newop", 64'(out_newop), 64'(OP_ADD));
    chk("addi.rd", 64'(out_rd), 64'd1);
    chk("addi.imm", 64'(out_imm), 64'd5);
    chk("addi.wr", 64'(out_wr_rd), 64'd1);
    chk("addi.cnt", 64'(count), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick("addi_pop");

    // BEQ x1,x2,+8
    drive(1'b0, 32'h0020_8463, 32'h200, 1'b0, 1'b0);
    chk("beq.nt_target", 64'(pred_target), 64'h204);
    drive(1'b1, 32'h0020_8463, 32'h200, 1'b1, 1'b0);
    chk("beq.t_target", 64'(pred_target), 64'h208);
    tick("beq");
    chk("beq.is_branch", 64'(out_is_branch), 64'd1);
    chk("beq.wr", 64'(out_wr_rd), 64'd0);
    chk("beq.rs2", 64'(out_rs2), 64'd2);
    chk("beq.imm", 64'(out_imm), 64'd8);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick("beq_pop");

    // JAL x1,16 then an all-ones word
    drive(1'b1, 32'h0100_00EF, 32'h300, 1'b0, 1'b0);
    chk("jal.target", 64'(pred_target), 64'h310);
    tick("jal");
    chk("jal.imm", 64'(out_imm), 64'd16);
    drive(1'b1, 32'hFFFF_FFFF, 32'h304, 1'b0, 1'b1);
    tick("ones");
    chk("ones.illegal", 64'(out_illegal), 64'd1);
    chk("ones.newop", 64'(out_newop), 64'(OP_NOP));
    chk("ones.wr", 64'(out_wr_rd), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick("ones_pop");

    // Fill to full, then stream with continuous pops.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, rand_inst(), 32'h400 + 32'(4 * i), 1'($urandom_range(0, 1)), 1'b0);
      tick("fill");
    end
    chk("full.in_ready", 64'(in_ready), 64'd0);
    chk("full.count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, rand_inst(), 32'h500 + 32'(4 * i), 1'($urandom_range(0, 1)), 1'b1);
      tick("stream");
    end

    // Drain, load three entries, then flush against a push and a pop.
    for (int i = 0; i < 8 && mq.size() != 0; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick("drain");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_inst(), 32'h600 + 32'(4 * i), 1'b0, 1'b0);
      tick("pre_flush");
    end
    chk("pre_flush.count", 64'(count), 64'd3);
    flush = 1'b1;
    drive(1'b1, 32'h0050_0093, 32'h700, 1'b0, 1'b1);
    tick("flush");
    flush = 1'b0;
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.out_valid", 64'(out_valid), 64'd0);

    // rdy low for three cycles with traffic offered.
    drive(1'b1, 32'h0010_0113, 32'h800, 1'b0, 1'b0);
    tick("pre_hold_a");
    tick("pre_hold_b");
    rdy = 1'b0;
    drive(1'b1, 32'h0020_0193, 32'h808, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      chk("hold.in_ready", 64'(in_ready), 64'd0);
      chk("hold.count", 64'(count), 64'd2);
    end
    rdy = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick("post_hold_a");
    tick("post_hold_b");

    // ADD x0,x1,x0 must not write.
    drive(1'b1, 32'h0000_8033, 32'h900, 1'b0, 1'b0);
    tick("add_x0");
    chk("add_x0.newop", 64'(out_newop), 64'(OP_ADD));
    chk("add_x0.rs1", 64'(out_rs1), 64'd1);
    chk("add_x0.wr", 64'(out_wr_rd), 64'd0);

    // Reset mid-operation takes effect without a clock edge.
    drive(1'b1, 32'h0030_0213, 32'h904, 1'b0, 1'b0);
    tick("pre_reset");
    rst = 1'b0;
    #1;
    mq.delete();
    chk("midrst.count", 64'(count), 64'd0);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.newop", 64'(out_newop), 64'd0);
    #1;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick("post_reset");

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 24) == 0);
      drive(($urandom_range(0, 3) != 0), rand_inst(), $urandom() & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
